// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner: matrix dimensions, key
// code width, the scanner FSM state encoding and the row priority encoder.
package keypad_pkg;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  // Rows are active-low; the lowest-index low row wins. Only called when at
  // least one row is low, so the fall-through value of 3 is never ambiguous.
  function automatic logic [1:0] lowest_low_row(input logic [ROWS-1:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync
// Two-flop synchroniser for the asynchronous, pulled-up keypad rows.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset (flops go to all ones = idle)
//   row_i  - raw row inputs from the matrix
//   row_o  - synchronised rows
module keypad_sync
  import keypad_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [ROWS-1:0] row_i,
  output logic [ROWS-1:0] row_o
);

  logic [ROWS-1:0] meta_q;
  logic [ROWS-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= row_i;
      sync_q <= meta_q;
    end
  end

  assign row_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low key matrix one column at a time, debounces press
// and release, and reports each accepted key as a one-cycle pulse with a
// held 4-bit code {row, col}.
// Ports:
//   clk           - system clock
//   reset         - synchronous active-high reset
//   key_row       - matrix rows, active-low, asynchronous
//   scan_enable   - when low, a completed press is accepted silently
//   key_col       - column drive, exactly one bit low
//   keypad_data   - last reported key code
//   keypad_enable - one-cycle pulse per reported press
//   key_held      - high while an accepted key is still down
//
// state       | meaning
// ST_SCAN     | rotating columns, sampling rows at the end of each slot
// ST_DEBOUNCE | column frozen, counting consecutive low cycles on row_idx
// ST_HELD     | key accepted, waiting for row_idx to go high
// ST_RELEASE  | counting consecutive high cycles before scanning again
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROWS-1:0]   key_row,
  input  logic              scan_enable,
  output logic [COLS-1:0]   key_col,
  output logic [CODE_W-1:0] keypad_data,
  output logic              keypad_enable,
  output logic              key_held
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CNT - 1);

  logic [ROWS-1:0]   rs;
  state_e            state_q,   state_d;
  logic [1:0]        col_q,     col_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [CW-1:0]     div_q,     div_d;
  logic [CW-1:0]     db_q,      db_d;
  logic [CODE_W-1:0] data_q,    data_d;
  logic              en_q,      en_d;
  logic              row_low;

  keypad_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .row_i (key_row),
    .row_o (rs)
  );

  assign row_low = ~rs[row_idx_q];

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_idx_d = row_idx_q;
    div_d     = div_q;
    db_d      = db_q;
    data_d    = data_q;
    en_d      = 1'b0;

    case (state_q)
      ST_SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (rs != '1) begin
            row_idx_d = lowest_low_row(rs);
            db_d      = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      ST_DEBOUNCE: begin
        if (row_low) begin
          if (db_q == DB_LAST) begin
            state_d = ST_HELD;
            // The enable decision is taken here, once; a press accepted
            // while disabled never produces a pulse later.
            if (scan_enable) begin
              en_d   = 1'b1;
              data_d = {row_idx_q, col_q};
            end
          end else begin
            db_d = db_q + 1'b1;
          end
        end else begin
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          div_d   = '0;
        end
      end

      ST_HELD: begin
        if (!row_low) begin
          state_d = ST_RELEASE;
          db_d    = '0;
        end
      end

      ST_RELEASE: begin
        if (row_low) begin
          state_d = ST_HELD;
        end else if (db_q == DB_LAST) begin
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          div_d   = '0;
        end else begin
          db_d = db_q + 1'b1;
        end
      end

      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_SCAN;
      col_q     <= 2'd0;
      row_idx_q <= 2'd0;
      div_q     <= '0;
      db_q      <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_idx_q <= row_idx_d;
      div_q     <= div_d;
      db_q      <= db_d;
      data_q    <= data_d;
      en_q      <= en_d;
    end
  end

  assign key_col       = ~(4'b0001 << col_q);
  assign keypad_data   = data_q;
  assign keypad_enable = en_q;
  assign key_held      = (state_q == ST_HELD) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8.
// A behavioural key matrix pulls a row low whenever a pressed key sits on
// the currently driven column; row_force_n lets a sequence pull rows low
// directly, independent of the column drive.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_row;
  logic        scan_enable;
  logic [3:0]  key_col;
  logic [3:0]  keypad_data;
  logic        keypad_enable;
  logic        key_held;

  logic [15:0] keys;
  logic [3:0]  row_force_n;
  int          pulse_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .key_row       (key_row),
    .scan_enable   (scan_enable),
    .key_col       (key_col),
    .keypad_data   (keypad_data),
    .keypad_enable (keypad_enable),
    .key_held      (key_held)
  );

  always_comb begin
    key_row = row_force_n;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  always @(negedge clk)
    if (keypad_enable === 1'b1) pulse_cnt <= pulse_cnt + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic wait_col(input logic [3:0] c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (key_col === c) ok = 1'b1;
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] keys;
    int          hold;
    int          en_low;
    int          exp_pulses;
    logic [3:0]  exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int  p0;
    bit  ok;

    vecs[0] = '{"r1c2",      16'h0040, 40, 0,  1, 4'd6};
    vecs[1] = '{"r0r3c1",    16'h2002, 40, 0,  1, 4'd1};
    vecs[2] = '{"r3c0_dis",  16'h1000, 60, 40, 0, 4'd1};
    vecs[3] = '{"r3c3",      16'h8000, 40, 0,  1, 4'd15};
    vecs[4] = '{"r0c0",      16'h0001, 40, 0,  1, 4'd0};
    vecs[5] = '{"r2c1",      16'h0200, 40, 0,  1, 4'd9};

    reset       = 1'b1;
    keys        = '0;
    row_force_n = 4'hF;
    scan_enable = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_key_col", {12'h0, key_col}, 16'hE);
    check("rst_data", {12'h0, keypad_data}, 16'h0);
    check("rst_enable", {15'h0, keypad_enable}, 16'h0);
    check("rst_held", {15'h0, key_held}, 16'h0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Press / hold / release vectors
    for (int v = 0; v < 6; v++) begin
      p0   = pulse_cnt;
      keys = vecs[v].keys;
      for (int i = 0; i < vecs[v].hold; i++) begin
        scan_enable = (i >= vecs[v].en_low);
        @(negedge clk);
      end
      scan_enable = 1'b1;
      check({vecs[v].name, "_held"}, {15'h0, key_held}, 16'h1);
      keys = '0;
      repeat (20) @(negedge clk);
      check({vecs[v].name, "_released"}, {15'h0, key_held}, 16'h0);
      check({vecs[v].name, "_pulses"}, 16'(pulse_cnt - p0), 16'(vecs[v].exp_pulses));
      check({vecs[v].name, "_data"}, {12'h0, keypad_data}, {12'h0, vecs[v].exp_data});
    end

    // Long hold with a second key on the same column, release bounce, re-press
    p0   = pulse_cnt;
    keys = 16'h0800;
    for (int i = 0; i < 200; i++) begin
      keys = (i >= 50 && i < 100) ? 16'h0808 : 16'h0800;
      @(negedge clk);
    end
    check("long_pulses", 16'(pulse_cnt - p0), 16'd1);
    check("long_data", {12'h0, keypad_data}, 16'd11);
    check("long_held", {15'h0, key_held}, 16'h1);
    keys = '0;     repeat (2) @(negedge clk);
    keys = 16'h0800; @(negedge clk);
    keys = '0;     repeat (20) @(negedge clk);
    check("bounce_released", {15'h0, key_held}, 16'h0);
    check("bounce_pulses", 16'(pulse_cnt - p0), 16'd1);
    keys = 16'h0800; repeat (40) @(negedge clk);
    keys = '0;       repeat (20) @(negedge clk);
    check("repress_pulses", 16'(pulse_cnt - p0), 16'd2);
    check("repress_data", {12'h0, keypad_data}, 16'd11);

    // Reset while HELD
    p0   = pulse_cnt;
    keys = 16'h0020;
    ok   = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (key_held === 1'b1) ok = 1'b1;
    end
    if (!ok) timeout("held_wait");
    repeat (3) @(negedge clk);
    check("pre_rst_pulses", 16'(pulse_cnt - p0), 16'd1);
    check("pre_rst_data", {12'h0, keypad_data}, 16'd5);
    reset = 1'b1;
    keys  = '0;
    @(negedge clk);
    check("midrst_key_col", {12'h0, key_col}, 16'hE);
    check("midrst_data", {12'h0, keypad_data}, 16'h0);
    check("midrst_held", {15'h0, key_held}, 16'h0);
    check("midrst_enable", {15'h0, keypad_enable}, 16'h0);
    reset = 1'b0;
    p0    = pulse_cnt;
    repeat (40) @(negedge clk);
    check("post_rst_pulses", 16'(pulse_cnt - p0), 16'd0);
    check("post_rst_held", {15'h0, key_held}, 16'h0);

    // Five-cycle glitch on row0 starting at the top of the col0 slot
    p0 = pulse_cnt;
    wait_col(4'b0111, ok);
    if (!ok) timeout("col3_wait");
    wait_col(4'b1110, ok);
    if (!ok) timeout("col0_wait");
    row_force_n = 4'b1110;
    repeat (5) @(negedge clk);
    row_force_n = 4'b1111;
    repeat (3) @(negedge clk);
    check("glitch_key_col", {12'h0, key_col}, 16'hD);
    check("glitch_held", {15'h0, key_held}, 16'h0);
    repeat (10) @(negedge clk);
    check("glitch_pulses", 16'(pulse_cnt - p0), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
